// File: rtl/mode7_pkg.sv
// Shared widths, FSM encoding and operand helpers for the mode7 line sequencer.
package mode7_pkg;
  localparam int CORNER_W = 29;
  localparam int EDGE_W   = 36;
  localparam int STRIDE_W = 33;
  localparam int RECIP_W  = 17;
  localparam int MUL_A_W  = 37;
  localparam int MUL_B_W  = 18;
  localparam int MUL_P_W  = MUL_A_W + MUL_B_W;
  localparam int FRAC_SH  = 16;

  typedef enum logic [2:0] {IDLE, EDGE, STRIDE, WB, PUBLISH} seq_state_t;

  // (hi - lo) >>> 16 at corner width + 1, sign-extended to multiplier A width
  function automatic logic [MUL_A_W-1:0] edge_delta(input logic [CORNER_W-1:0] hi,
                                                     input logic [CORNER_W-1:0] lo);
    logic signed [CORNER_W:0] d;
    d = $signed({hi[CORNER_W-1], hi}) - $signed({lo[CORNER_W-1], lo});
    d = d >>> FRAC_SH;
    return {{(MUL_A_W-CORNER_W-1){d[CORNER_W]}}, d};
  endfunction

  function automatic logic [MUL_A_W-1:0] span_delta(input logic [EDGE_W-1:0] hi,
                                                     input logic [EDGE_W-1:0] lo);
    return {hi[EDGE_W-1], hi} - {lo[EDGE_W-1], lo};
  endfunction
endpackage

// File: rtl/mode7_shared_mul.sv
// Registered signed 37x18 multiplier, one op per cycle, no datapath reset.
module mode7_shared_mul
  import mode7_pkg::*;
(
  input  logic                      clk,
  input  logic signed [MUL_A_W-1:0] a,
  input  logic signed [MUL_B_W-1:0] b,
  output logic signed [MUL_P_W-1:0] p
);
  always_ff @(posedge clk) p <= a * b;
endmodule

// File: rtl/mode7_line_sequencer.sv
// Per-line mode7 parameter sequencer on one shared multiplier.
// MODE7_SEQ_OVERRUN_EN enables the sticky overrun flag (tied 0 otherwise).
module mode7_line_sequencer
  import mode7_pkg::*;
#(
  parameter logic [7:0] STRIDE_RECIP = 8'd102,
  parameter int         MUL_LAT      = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_start,
  input  logic                       line_start,
  input  logic signed [CORNER_W-1:0] a_u,
  input  logic signed [CORNER_W-1:0] a_v,
  input  logic signed [CORNER_W-1:0] b_u,
  input  logic signed [CORNER_W-1:0] b_v,
  input  logic signed [CORNER_W-1:0] c_u,
  input  logic signed [CORNER_W-1:0] c_v,
  input  logic signed [CORNER_W-1:0] d_u,
  input  logic signed [CORNER_W-1:0] d_v,
  input  logic        [RECIP_W-1:0]  one_over_y,
  output logic signed [EDGE_W-1:0]   u_start,
  output logic signed [EDGE_W-1:0]   v_start,
  output logic signed [STRIDE_W-1:0] u_stride,
  output logic signed [STRIDE_W-1:0] v_stride,
  output logic                       params_valid,
  output logic                       busy,
  output logic                       overrun
);
  if (MUL_LAT != 1) begin : g_lat_chk
    $error("mode7_line_sequencer: only MUL_LAT=1 is supported");
  end

  seq_state_t state, state_nxt;
  logic [1:0] idx, idx_nxt;

  // cr[0..3] = a_u,a_v,b_u,b_v (far corners), cr[4..7] = c_u,c_v,d_u,d_v (near/base)
  logic [7:0][CORNER_W-1:0] cr;
  logic [3:0][EDGE_W-1:0]   edge_r;   // left_u, left_v, right_u, right_v
  logic [STRIDE_W-1:0]      stride_u_r;

  logic signed [MUL_A_W-1:0] mul_a;
  logic signed [MUL_B_W-1:0] mul_b;
  logic signed [MUL_P_W-1:0] prod;
  logic                      cap_en;
  logic [1:0]                cap_slot;
  logic [CORNER_W-1:0]       cap_base;
  logic [EDGE_W-1:0]         edge_sum;

  mode7_shared_mul u_mul (.clk(clk), .a(mul_a), .b(mul_b), .p(prod));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    if (frame_start) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
    end else begin
      case (state)
        IDLE:    if (line_start) begin state_nxt = EDGE; idx_nxt = '0; end
        EDGE:    if (idx == 2'd3) begin state_nxt = STRIDE; idx_nxt = '0; end
                 else idx_nxt = idx + 2'd1;
        STRIDE:  if (idx[0]) begin state_nxt = WB; idx_nxt = '0; end
                 else idx_nxt = idx + 2'd1;
        WB:      state_nxt = PUBLISH;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    mul_a        = '0;
    mul_b        = '0;
    busy         = (state != IDLE);
    params_valid = (state == PUBLISH);
    case (state)
      EDGE: begin
        mul_a = edge_delta(cr[{1'b0, idx}], cr[{1'b1, idx}]);
        mul_b = {1'b0, one_over_y};
      end
      STRIDE: begin
        mul_a = idx[0] ? span_delta(edge_r[3], edge_r[1]) : span_delta(edge_r[2], edge_r[0]);
        mul_b = {{(MUL_B_W-8){1'b0}}, STRIDE_RECIP};
      end
      default: ;
    endcase
  end

  // Product of the op issued last cycle lands here; edge results add the base corner.
  always_comb begin
    cap_en   = 1'b0;
    cap_slot = '0;
    if (state == EDGE && idx != 2'd0) begin
      cap_en   = 1'b1;
      cap_slot = idx - 2'd1;
    end else if (state == STRIDE && !idx[0]) begin
      cap_en   = 1'b1;
      cap_slot = 2'd3;
    end
    cap_base = cr[{1'b1, cap_slot}];
    edge_sum = {{(EDGE_W-CORNER_W){cap_base[CORNER_W-1]}}, cap_base} + prod[EDGE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cr       <= '0;
      u_start  <= '0;
      v_start  <= '0;
      u_stride <= '0;
      v_stride <= '0;
    end else begin
      if (frame_start) cr <= {d_v, d_u, c_v, c_u, b_v, b_u, a_v, a_u};
      if (cap_en) edge_r[cap_slot] <= edge_sum;
      if (state == STRIDE && idx[0]) stride_u_r <= prod[FRAC_SH +: STRIDE_W];
      if (state == WB && !frame_start) begin
        u_start  <= edge_r[0];
        v_start  <= edge_r[1];
        u_stride <= stride_u_r;
        v_stride <= prod[FRAC_SH +: STRIDE_W];
      end
    end
  end

`ifdef MODE7_SEQ_OVERRUN_EN
  logic overrun_r;
  always_ff @(posedge clk) begin
    if (rst)                              overrun_r <= 1'b0;
    else if (frame_start)                 overrun_r <= 1'b0;
    else if (line_start && state != IDLE) overrun_r <= 1'b1;
  end
  assign overrun = overrun_r;
`else
  assign overrun = 1'b0;
`endif
endmodule

// File: tb/tb_mode7_line_sequencer.sv
// Self-checking bench: directed cases plus random traffic against a line-level model.
module tb_mode7_line_sequencer;
  localparam longint RECIP = 102;

  logic clk = 0, rst = 1, frame_start = 0, line_start = 0;
  logic signed [28:0] a_u = 0, a_v = 0, b_u = 0, b_v = 0, c_u = 0, c_v = 0, d_u = 0, d_v = 0;
  logic [16:0] one_over_y = 0;
  logic signed [35:0] u_start, v_start;
  logic signed [32:0] u_stride, v_stride;
  logic params_valid, busy, overrun;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  mode7_line_sequencer #(.STRIDE_RECIP(8'd102), .MUL_LAT(1)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .line_start(line_start),
    .a_u(a_u), .a_v(a_v), .b_u(b_u), .b_v(b_v), .c_u(c_u), .c_v(c_v), .d_u(d_u), .d_v(d_v),
    .one_over_y(one_over_y), .u_start(u_start), .v_start(v_start),
    .u_stride(u_stride), .v_stride(v_stride),
    .params_valid(params_valid), .busy(busy), .overrun(overrun));

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sx(input longint x, input int w);
    return (x <<< (64 - w)) >>> (64 - w);
  endfunction

  // Line parameters straight from the frustum formulas.
  function automatic void ref_line(input longint cr[8], input longint oy,
                                   output longint us, output longint vs,
                                   output longint ust, output longint vst);
    longint lu, lv, ru, rv;
    lu = sx(cr[4] + ((cr[0] - cr[4]) >>> 16) * oy, 36);
    lv = sx(cr[5] + ((cr[1] - cr[5]) >>> 16) * oy, 36);
    ru = sx(cr[6] + ((cr[2] - cr[6]) >>> 16) * oy, 36);
    rv = sx(cr[7] + ((cr[3] - cr[7]) >>> 16) * oy, 36);
    us  = lu;
    vs  = lv;
    ust = sx(((ru - lu) * RECIP) >>> 16, 33);
    vst = sx(((rv - lv) * RECIP) >>> 16, 33);
  endfunction

  // Model: m_age counts cycles since an accepted line_start (0 = idle, 8 = publish).
  longint m_cr[8] = '{default: 0};
  longint m_us = 0, m_vs = 0, m_ust = 0, m_vst = 0;
  longint p_us = 0, p_vs = 0, p_ust = 0, p_vst = 0;
  int m_age = 0, m_prev = 0;
  bit m_ovr = 0, started = 0;

  always @(posedge clk) begin
    m_prev = m_age;
    if (rst) begin
      m_cr = '{default: 0};
      m_us = 0; m_vs = 0; m_ust = 0; m_vst = 0;
      m_age = 0; m_ovr = 0; started = 1;
    end else begin
      if (m_age == 8) m_age = 0;
      else if (m_age != 0) m_age++;
      if (frame_start) begin
        m_cr = '{longint'(a_u), longint'(a_v), longint'(b_u), longint'(b_v),
                 longint'(c_u), longint'(c_v), longint'(d_u), longint'(d_v)};
        m_ovr = 0;
        m_age = 0;
      end else if (line_start) begin
        if (m_prev != 0) m_ovr = 1;
        else begin
          m_age = 1;
          ref_line(m_cr, longint'(one_over_y), p_us, p_vs, p_ust, p_vst);
        end
      end
      if (m_age == 8) begin
        m_us = p_us; m_vs = p_vs; m_ust = p_ust; m_vst = p_vst;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("busy", busy, m_age != 0);
      chk("params_valid", params_valid, m_age == 8);
      chk("u_start", u_start, m_us);
      chk("v_start", v_start, m_vs);
      chk("u_stride", u_stride, m_ust);
      chk("v_stride", v_stride, m_vst);
`ifdef MODE7_SEQ_OVERRUN_EN
      chk("overrun", overrun, m_ovr);
`else
      chk("overrun", overrun, 0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame(input longint au, input longint av, input longint bu, input longint bv,
                            input longint cu, input longint cv, input longint du, input longint dv);
    a_u = 29'(au); a_v = 29'(av); b_u = 29'(bu); b_v = 29'(bv);
    c_u = 29'(cu); c_v = 29'(cv); d_u = 29'(du); d_v = 29'(dv);
    frame_start = 1;
    tick();
    frame_start = 0;
  endtask

  // Pulse line_start; returns cycle offset of params_valid (21 = timeout) and busy cycles.
  task automatic run_line(output int lat, output int bcnt);
    line_start = 1;
    tick();
    line_start = 0;
    lat = 21;
    bcnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (params_valid) begin lat = k; break; end
    end
    tick();
  endtask

  task automatic count_pv(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (params_valid) cnt++;
    end
    tick();
  endtask

  int lat, bcnt, npv;
  longint pc[8];
  longint t_us, t_vs, t_ust, t_vst;

  initial begin
    // pin the model itself on the hand-computed frustum example
    pc = '{longint'(32'h120000), 0, longint'(32'h140000), 0, longint'(32'h100000), 0, longint'(32'h100000), 0};
    ref_line(pc, longint'(32'h8000), t_us, t_vs, t_ust, t_vst);
    chk("model_u_start", t_us, 64'sh110000);
    chk("model_u_stride", t_ust, 102);
    pc = '{0, -longint'(32'h20000), 0, 0, 0, 0, 0, 0};
    ref_line(pc, longint'(32'h10000), t_us, t_vs, t_ust, t_vst);
    chk("model_v_start", t_vs, -64'sh20000);

    rst = 1;
    tick(); tick();
    rst = 0;
    @(negedge clk);
    chk("reset_u_start", u_start, 0);
    chk("reset_busy", busy, 0);
    tick();

    // all zero corners
    one_over_y = 0;
    run_line(lat, bcnt);
    chk("zero_latency", lat, 8);
    chk("zero_busy_cycles", bcnt, 8);
    chk("zero_u_start", u_start, 0);
    chk("zero_v_stride", v_stride, 0);

    // positive u frustum
    load_frame(32'h120000, 0, 32'h140000, 0, 32'h100000, 0, 32'h100000, 0);
    one_over_y = 17'h08000;
    run_line(lat, bcnt);
    chk("u_latency", lat, 8);
    chk("u_start_lit", u_start, 64'sh110000);
    chk("u_stride_lit", u_stride, 102);

    // negative v edge, sign through all 36 bits
    load_frame(32'h120000, -32'sh20000, 32'h140000, 0, 32'h100000, 0, 32'h100000, 0);
    one_over_y = 17'h10000;
    run_line(lat, bcnt);
    chk("v_start_lit", v_start, -64'sh20000);
    chk("v_stride_lit", v_stride, 204);
    chk("u_start_lit2", u_start, 64'sh120000);

    // second line_start at T+3 is dropped
    line_start = 1; tick(); line_start = 0;
    tick(); tick();
    line_start = 1; tick(); line_start = 0;
    count_pv(12, npv);
    chk("overrun_single_pv", npv, 1);
`ifdef MODE7_SEQ_OVERRUN_EN
    chk("overrun_set", overrun, 1);
`else
    chk("overrun_set", overrun, 0);
`endif
    load_frame(32'h120000, -32'sh20000, 32'h140000, 0, 32'h100000, 0, 32'h100000, 0);
    @(negedge clk);
    chk("overrun_cleared", overrun, 0);
    tick();

    // frame_start at T+4 aborts, outputs held, new corners used next
    line_start = 1; tick(); line_start = 0;
    tick(); tick(); tick();
    load_frame(32'h230000, 0, 0, 0, 32'h200000, 0, 0, 0);
    count_pv(12, npv);
    chk("abort_no_pv", npv, 0);
    chk("abort_hold_u", u_start, 64'sh120000);
    chk("abort_hold_v", v_start, -64'sh20000);
    run_line(lat, bcnt);
    chk("new_corner_u", u_start, 64'sh230000);
    chk("new_corner_stride", u_stride, -3570);

    // reset at T+5 cancels
    line_start = 1; tick(); line_start = 0;
    tick(); tick(); tick(); tick();
    rst = 1; tick(); rst = 0;
    count_pv(12, npv);
    chk("rst_no_pv", npv, 0);
    chk("rst_u_start", u_start, 0);
    chk("rst_u_stride", u_stride, 0);
    line_start = 1; tick(); line_start = 0;
    tick(); tick();
    line_start = 1; tick(); line_start = 0;
    count_pv(12, npv);
    chk("rerun_single_pv", npv, 1);
`ifdef MODE7_SEQ_OVERRUN_EN
    chk("rerun_overrun", overrun, 1);
`else
    chk("rerun_overrun", overrun, 0);
`endif

    // random traffic; one_over_y only moves while the model is idle
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      rst         = (r >= 98);
      frame_start = (r < 7);
      line_start  = ($urandom_range(0, 3) == 0);
      a_u = 29'($urandom); a_v = 29'($urandom); b_u = 29'($urandom); b_v = 29'($urandom);
      c_u = 29'($urandom); c_v = 29'($urandom); d_u = 29'($urandom); d_v = 29'($urandom);
      if (m_age == 0 && $urandom_range(0, 2) == 0) one_over_y = 17'($urandom);
      tick();
    end
    rst = 0; frame_start = 0; line_start = 0;
    repeat (12) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mode7_line_sequencer.md
MODE7_LINE_SEQUENCER -- requirements
Module: mode7_line_sequencer

Interface
REQ-001 SHALL have parameter STRIDE_RECIP, default 102, unsigned 8-bit reciprocal of 640 in 0.16 format used for the stride multiply.
REQ-002 SHALL have parameter MUL_LAT, default 1, latency in cycles of the shared multiplier; only 1 is supported.
REQ-003 clk  input  1  pixel clock; the block's only clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 frame_start  input  1  one-cycle pulse in vertical blanking; latches the corner inputs.
REQ-006 line_start  input  1  one-cycle pulse at the end of the active line (xpos==639); requests next-line parameters.
REQ-007 a_u, a_v, b_u, b_v, c_u, c_v, d_u, d_v  input  29 each, signed  frustum corners in texture space.
REQ-008 one_over_y  input  17  unsigned 0.16 reciprocal for the next line; must be stable from line_start until params_valid.
REQ-009 u_start, v_start  output  36 signed  texture coordinates at x=0 for the next line.
REQ-010 u_stride, v_stride  output  33 signed  per-pixel texture steps.
REQ-011 params_valid  output  1  one-cycle pulse; all four parameter outputs update on this same cycle.
REQ-012 busy  output  1  high while a sequence is in flight.
REQ-013 overrun  output  1  sticky flag: a line_start was dropped.

Function
REQ-014 SHALL compute left_u = c_u + ((a_u-c_u)>>>16)*one_over_y, with left_v, right_u and right_v formed the same way (right uses b/d); results are sign-extended to 36 bits.
REQ-015 SHALL compute u_stride = ((right_u-left_u)*STRIDE_RECIP)>>>16, and v_stride the same way; results are 33 bits.
REQ-016 SHALL perform every multiply on one shared registered signed multiplier: 37-bit by 18-bit operands, 55-bit product, 1-cycle latency, one operation issued per cycle.
REQ-017 FSM states: IDLE, EDGE (op index 0..3), STRIDE (op index 0..1), WB, PUBLISH.
REQ-018 line_start sampled in IDLE at cycle T: EDGE issues left_u, left_v, right_u, right_v at T+1..T+4; STRIDE issues u, then v, at T+5 and T+6; WB captures the last product at T+7; PUBLISH drives params_valid at T+8, then returns to IDLE.
REQ-019 Latency from line_start to params_valid SHALL be exactly 8 cycles; busy is high from T+1 to T+8 inclusive.
REQ-020 Parameter outputs SHALL hold their values between params_valid pulses.
REQ-021 line_start while busy SHALL be ignored and SHALL set overrun.
REQ-022 frame_start SHALL latch all eight corners and clear overrun in any state.
REQ-023 frame_start while busy SHALL abort the sequence and return to IDLE the next cycle; no params_valid is issued and the outputs are unchanged.
REQ-024 frame_start together with line_start in IDLE: frame_start wins; line_start is dropped without setting overrun.
REQ-025 Subtractions SHALL be computed at full width plus 1 bit, and arithmetic shifts SHALL preserve sign; no saturation is applied.

Reset
REQ-026 rst SHALL force IDLE and clear the corner registers, u_start, v_start, u_stride, v_stride, params_valid, busy and overrun to 0 on the next clk edge.
REQ-027 rst mid-sequence SHALL cancel it; no params_valid follows.

Configuration
REQ-028 Macro MODE7_SEQ_OVERRUN_EN defined: overrun behaves per REQ-021/022.
REQ-029 Macro MODE7_SEQ_OVERRUN_EN undefined: overrun is tied 0 and its logic is absent; dropping line_start is unchanged.

Structure
REQ-030 Package mode7_pkg SHALL hold CORNER_W=29, EDGE_W=36, STRIDE_W=33, RECIP_W=17, MUL_A_W=37, MUL_B_W=18 and the FSM state enum.
REQ-031 Sub-module mode7_shared_mul SHALL implement the registered signed multiplier; it has no reset on the datapath.

Verification
REQ-032 All corners 0, one_over_y=0, pulse line_start -> params_valid at exactly T+8 with all outputs 0; busy high for 8 cycles.
REQ-033 c_u=0x100000, a_u=0x120000, d_u=0x100000, b_u=0x140000, one_over_y=0x8000, pulse line_start -> u_start=0x110000, u_stride=(0x10000*102)>>>16=102.
REQ-034 a_v-c_v=-0x20000, c_v=0, one_over_y=0x10000 -> v_start=-0x20000, with sign correct in all 36 bits.
REQ-035 Second line_start at T+3 -> ignored; overrun=1; a single params_valid at T+8; the next frame_start clears overrun.
REQ-036 frame_start at T+4 of a sequence -> no params_valid and previous outputs held; new corners are used by the following line_start.
REQ-037 rst at T+5 -> all outputs 0 and no params_valid; with MODE7_SEQ_OVERRUN_EN undefined, rerun REQ-035 -> overrun stays 0.
